video_ram_scheduler: RTL and testbench

Shares the single read port of the CPU video RAM (8-bit address, 4-bit nibble data) among three requesters: LCD scanout, the per-frame icon fetch, and an auxiliary reader (debug/savestate). Scheduling is fixed-priority and read data is routed back by owner tag. The icon fetch sequencer is built in: on each vsync it reads the two icon nibbles and publishes an 8-bit `sprite_enable_status` to the sprite layer. The block sits between `video_gen`/`lcd` and the video RAM, and replaces ad-hoc address muxing in the video top level.

---
 rtl/video_pkg.sv | 27 ++
 rtl/read_tag_pipe.sv | 48 ++++
 rtl/video_ram_scheduler.sv | 154 +++++++++++++++
 tb/tb_video_ram_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the video RAM read scheduler.
// Owners tag each read so its data can be routed back when it returns.
package video_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LCD  = 2'd1,
        OWN_ICON = 2'd2,
        OWN_AUX  = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_UP = 2'd1,
        REQ_LO = 2'd2,
        WAIT   = 2'd3
    } icon_state_t;

    typedef struct packed {
        logic   vld;
        owner_t owner;
    } tag_t;

    localparam logic [7:0] ICON_ADDR_UPPER_DEF = 8'h10;
    localparam logic [7:0] ICON_ADDR_LOWER_DEF = 8'h89;

endpackage

// File: rtl/read_tag_pipe.sv
// Delay line carrying {valid, owner} alongside each outstanding RAM read.
// flush_icon removes icon-owned entries so an aborted fetch never returns.
module read_tag_pipe
    import video_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_vld,
    input  logic [1:0] in_owner,
    input  logic       flush_icon,
    output logic       out_vld,
    output logic [1:0] out_owner
);

    tag_t stage_p [DEPTH];
    tag_t in_tag;

    function automatic tag_t drop_icon(tag_t t, logic flush);
        tag_t r;
        r = t;
        if (flush && t.owner == OWN_ICON) begin
            r.vld   = 1'b0;
            r.owner = OWN_NONE;
        end
        return r;
    endfunction

    assign in_tag = '{vld: in_vld, owner: owner_t'(in_owner)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_p[i] <= '{vld: 1'b0, owner: OWN_NONE};
            end
        end else begin
            stage_p[0] <= drop_icon(in_tag, flush_icon);
            for (int i = 1; i < DEPTH; i++) begin
                stage_p[i] <= drop_icon(stage_p[i-1], flush_icon);
            end
        end
    end

    assign out_vld   = stage_p[DEPTH-1].vld;
    assign out_owner = stage_p[DEPTH-1].owner;

endmodule

// File: rtl/video_ram_scheduler.sv
// Fixed-priority (LCD > icon > aux) arbiter for the video RAM read port,
// with the per-frame icon fetch sequencer and owner-tagged data return.
module video_ram_scheduler
    import video_pkg::*;
#(
    parameter int         RAM_LATENCY     = 1,
    parameter logic [7:0] ICON_ADDR_UPPER = ICON_ADDR_UPPER_DEF,
    parameter logic [7:0] ICON_ADDR_LOWER = ICON_ADDR_LOWER_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       lcd_req,
    input  logic [7:0] lcd_addr,
    output logic       lcd_valid,
    output logic [3:0] lcd_data,
    input  logic       aux_req,
    input  logic [7:0] aux_addr,
    output logic       aux_ack,
    output logic       aux_valid,
    output logic [3:0] aux_data,
    output logic [7:0] ram_addr,
    input  logic [3:0] ram_data,
    output logic [7:0] sprite_enable_status,
    output logic       icon_status_valid
);

    icon_state_t state, state_nxt;
    logic        vsync_q;
    logic        vsync_rise;
    logic        icon_req;
    logic [7:0]  icon_addr;
    logic        grant_lcd, grant_icon, grant_aux;
    owner_t      grant_owner;
    logic        tag_vld;
    logic [1:0]  tag_owner;
    logic        ret_lcd, ret_icon, ret_aux;
    logic        got_up;
    logic [3:0]  shadow_up;
    logic        commit;
    logic [3:0]  lcd_data_q, aux_data_q;

    assign vsync_rise = vsync & ~vsync_q;

    // A restarting edge suppresses this cycle's icon request so nothing stale is issued.
    assign icon_req  = (state == REQ_UP || state == REQ_LO) && !vsync_rise;
    assign icon_addr = (state == REQ_LO) ? ICON_ADDR_LOWER : ICON_ADDR_UPPER;

    assign grant_lcd  = lcd_req;
    assign grant_icon = icon_req & ~lcd_req;
    assign grant_aux  = aux_req & ~lcd_req & ~icon_req;
    assign aux_ack    = grant_aux;

    always_comb begin
        grant_owner = OWN_NONE;
        ram_addr    = 8'h00;
        if (grant_lcd) begin
            grant_owner = OWN_LCD;
            ram_addr    = lcd_addr;
        end else if (grant_icon) begin
            grant_owner = OWN_ICON;
            ram_addr    = icon_addr;
        end else if (grant_aux) begin
            grant_owner = OWN_AUX;
            ram_addr    = aux_addr;
        end
    end

    read_tag_pipe #(
        .DEPTH(RAM_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_vld    (grant_owner != OWN_NONE),
        .in_owner  (grant_owner),
        .flush_icon(vsync_rise),
        .out_vld   (tag_vld),
        .out_owner (tag_owner)
    );

    assign ret_lcd  = tag_vld && (tag_owner == OWN_LCD);
    assign ret_aux  = tag_vld && (tag_owner == OWN_AUX);
    assign ret_icon = tag_vld && (tag_owner == OWN_ICON) && !vsync_rise;

    assign lcd_valid = ret_lcd;
    assign aux_valid = ret_aux;
    assign lcd_data  = ret_lcd ? ram_data : lcd_data_q;
    assign aux_data  = ret_aux ? ram_data : aux_data_q;

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        if (vsync_rise) begin
            state_nxt = REQ_UP;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                REQ_UP:  if (grant_icon) state_nxt = REQ_LO;
                REQ_LO:  if (grant_icon) state_nxt = WAIT;
                WAIT: begin
                    // Icon returns arrive in issue order, so the second one is the lower nibble.
                    if (ret_icon && got_up) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= vsync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            got_up               <= 1'b0;
            shadow_up            <= 4'h0;
            sprite_enable_status <= 8'h00;
            icon_status_valid    <= 1'b0;
            lcd_data_q           <= 4'h0;
            aux_data_q           <= 4'h0;
        end else begin
            icon_status_valid <= commit;
            if (vsync_rise) begin
                got_up <= 1'b0;
            end else if (ret_icon) begin
                if (!got_up) begin
                    shadow_up <= ram_data;
                    got_up    <= 1'b1;
                end else begin
                    got_up <= 1'b0;
                end
            end
            if (commit) begin
                sprite_enable_status <= {ram_data, shadow_up};
            end
            if (ret_lcd) begin
                lcd_data_q <= ram_data;
            end
            if (ret_aux) begin
                aux_data_q <= ram_data;
            end
        end
    end

endmodule

// File: tb/tb_video_ram_scheduler.sv
// Scoreboard bench: directed stimulus pushes expected {data, cycle} items,
// a negedge monitor pops and compares whenever a valid output appears.
module tb_video_ram_scheduler;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       reset_n;
    // Latency-1 instance
    logic       vsync, lcd_req, aux_req;
    logic [7:0] lcd_addr, aux_addr;
    logic       lcd_valid, aux_ack, aux_valid, icon_status_valid;
    logic [3:0] lcd_data, aux_data, ram_data;
    logic [7:0] ram_addr, sprite_enable_status;
    // Latency-3 instance
    logic       vsync3, lcd3_req, aux3_req;
    logic [7:0] lcd3_addr, aux3_addr;
    logic       lcd3_valid, aux3_ack, aux3_valid, isv3;
    logic [3:0] lcd3_data, aux3_data, ram3_data;
    logic [7:0] ram3_addr, status3;

    logic [3:0] mem1 [256];
    logic [3:0] mem3 [256];
    logic [7:0] a1_d;
    logic [7:0] a3_d [3];

    always @(posedge clk) begin
        a1_d    <= ram_addr;
        a3_d[0] <= ram3_addr;
        a3_d[1] <= a3_d[0];
        a3_d[2] <= a3_d[1];
    end
    assign ram_data  = mem1[a1_d];
    assign ram3_data = mem3[a3_d[2]];

    video_ram_scheduler #(.RAM_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .vsync(vsync),
        .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_valid(lcd_valid), .lcd_data(lcd_data),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_ack(aux_ack),
        .aux_valid(aux_valid), .aux_data(aux_data),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .sprite_enable_status(sprite_enable_status), .icon_status_valid(icon_status_valid)
    );

    video_ram_scheduler #(.RAM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .vsync(vsync3),
        .lcd_req(lcd3_req), .lcd_addr(lcd3_addr), .lcd_valid(lcd3_valid), .lcd_data(lcd3_data),
        .aux_req(aux3_req), .aux_addr(aux3_addr), .aux_ack(aux3_ack),
        .aux_valid(aux3_valid), .aux_data(aux3_data),
        .ram_addr(ram3_addr), .ram_data(ram3_data),
        .sprite_enable_status(status3), .icon_status_valid(isv3)
    );

    exp_t lq[$], aq[$], sq[$], l3q[$], a3q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s unexpected valid cyc=%0d", name, cyc);
    endtask

    // Monitor: every presented output must match the head of its queue, in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (lcd_valid) begin
            if (lq.size() == 0) unexpected("lcd");
            else begin e = lq.pop_front(); chk("lcd_data", int'(lcd_data), e.data); chk("lcd_cyc", cyc, e.cyc); end
        end
        if (aux_valid) begin
            if (aq.size() == 0) unexpected("aux");
            else begin e = aq.pop_front(); chk("aux_data", int'(aux_data), e.data); chk("aux_cyc", cyc, e.cyc); end
        end
        if (icon_status_valid) begin
            if (sq.size() == 0) unexpected("status");
            else begin e = sq.pop_front(); chk("status", int'(sprite_enable_status), e.data); chk("status_cyc", cyc, e.cyc); end
        end
        if (lcd3_valid) begin
            if (l3q.size() == 0) unexpected("lcd3");
            else begin e = l3q.pop_front(); chk("lcd3_data", int'(lcd3_data), e.data); chk("lcd3_cyc", cyc, e.cyc); end
        end
        if (aux3_valid) begin
            if (a3q.size() == 0) unexpected("aux3");
            else begin e = a3q.pop_front(); chk("aux3_data", int'(aux3_data), e.data); chk("aux3_cyc", cyc, e.cyc); end
        end
        if (isv3) unexpected("status3");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int t0;
    bit acked;

    initial begin
        reset_n = 1'b0;
        vsync = 0; lcd_req = 0; aux_req = 0; lcd_addr = 0; aux_addr = 0;
        vsync3 = 0; lcd3_req = 0; aux3_req = 0; lcd3_addr = 0; aux3_addr = 0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 4'h0;
            mem3[i] = 4'h0;
        end
        mem1[8'h10] = 4'hA; mem1[8'h89] = 4'h5; mem1[8'h20] = 4'h7; mem1[8'h33] = 4'hC;
        mem3[8'h40] = 4'h1; mem3[8'h41] = 4'h2; mem3[8'h42] = 4'h3; mem3[8'h43] = 4'h4;

        // Reset state
        step(); step(); sample();
        chk("rst_status", int'(sprite_enable_status), 0);
        chk("rst_isv", int'(icon_status_valid), 0);
        chk("rst_lcd_valid", int'(lcd_valid), 0);
        chk("rst_aux_valid", int'(aux_valid), 0);
        chk("rst_lcd_data", int'(lcd_data), 0);
        chk("rst_aux_data", int'(aux_data), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_aux_ack", int'(aux_ack), 0);
        chk("rst_status3", int'(status3), 0);
        step(); reset_n = 1'b1;
        step(); step();

        // Uncontended icon fetch
        step(); t0 = cyc; vsync = 1;
        sq.push_back('{8'h5A, t0 + 4});
        step(); vsync = 0; sample(); chk("t1_addr_up", int'(ram_addr), 8'h10);
        step(); sample(); chk("t1_addr_lo", int'(ram_addr), 8'h89);
        step(); sample(); chk("t1_no_half", int'(sprite_enable_status), 0);
        step(); step(); sample(); chk("t1_status", int'(sprite_enable_status), 8'h5A);
        step(); step();

        // LCD contention for three cycles, aux waiting behind both
        step(); t0 = cyc; vsync = 1;
        sq.push_back('{8'h5A, t0 + 7});
        acked = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            vsync    = 0;
            lcd_req  = (i <= 3);
            lcd_addr = 8'h20;
            aux_addr = 8'h33;
            if (i == 1) aux_req = 1;
            if (acked) aux_req = 0;
            if (lcd_req) lq.push_back('{4'h7, cyc + 1});
            sample();
            if (i == 4) chk("t2_addr_up", int'(ram_addr), 8'h10);
            if (aux_ack) begin
                chk("t2_aux_ack_cyc", cyc, t0 + 6);
                aq.push_back('{4'hC, cyc + 1});
                acked = 1;
            end
        end
        chk("t2_aux_acked", int'(acked), 1);
        lcd_req = 0; aux_req = 0;
        step(); step();

        // Uncontended aux read
        step(); aux_req = 1; aux_addr = 8'h33;
        sample(); chk("t3_aux_ack", int'(aux_ack), 1);
        aq.push_back('{4'hC, cyc + 1});
        step(); aux_req = 0;
        sample(); chk("t3_aux_ack_drop", int'(aux_ack), 0);
        step(); step();

        // Second vsync edge mid-fetch restarts it with new lower contents
        mem1[8'h89] = 4'h3;
        step(); t0 = cyc; vsync = 1;
        sq.push_back('{8'h3A, t0 + 6});
        step(); vsync = 0;
        step(); vsync = 1;
        step(); vsync = 0;
        for (int i = 4; i <= 9; i++) begin
            step(); sample();
            if (cyc == t0 + 5) chk("t4_old_status", int'(sprite_enable_status), 8'h5A);
            if (cyc == t0 + 7) chk("t4_new_status", int'(sprite_enable_status), 8'h3A);
        end

        // Reset in the middle of a fetch with an LCD read in flight
        step(); t0 = cyc; vsync = 1;
        step(); vsync = 0; lcd_req = 1; lcd_addr = 8'h20;
        step(); lcd_req = 0; reset_n = 0;
        sample();
        chk("t5_status", int'(sprite_enable_status), 0);
        chk("t5_lcd_valid", int'(lcd_valid), 0);
        chk("t5_isv", int'(icon_status_valid), 0);
        step(); step(); reset_n = 1;
        for (int i = 0; i < 6; i++) step();
        sample(); chk("t5_status_after", int'(sprite_enable_status), 0);

        // Latency 3, interleaved LCD and aux
        step(); lcd3_req = 1; lcd3_addr = 8'h40; l3q.push_back('{4'h1, cyc + 3});
        step(); lcd3_req = 0; aux3_req = 1; aux3_addr = 8'h41;
        sample(); chk("t6_ack1", int'(aux3_ack), 1); a3q.push_back('{4'h2, cyc + 3});
        step(); aux3_req = 0; lcd3_req = 1; lcd3_addr = 8'h42; l3q.push_back('{4'h3, cyc + 3});
        step(); lcd3_req = 0; aux3_req = 1; aux3_addr = 8'h43;
        sample(); chk("t6_ack2", int'(aux3_ack), 1); a3q.push_back('{4'h4, cyc + 3});
        step(); aux3_req = 0;
        for (int i = 0; i < 6; i++) step();

        // Everything expected must have been seen
        chk("left_lcd", lq.size(), 0);
        chk("left_aux", aq.size(), 0);
        chk("left_status", sq.size(), 0);
        chk("left_lcd3", l3q.size(), 0);
        chk("left_aux3", a3q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
